// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage bus bundle between fetch_unit and its neighbours
//
// Purpose: groups the fetch stage control inputs, the instruction memory
// address/data pair and the IF/ID pipeline register outputs.
// Ports (signals):
//   stall, branch_taken, branch_target   control from decode/execute
//   instruction_set                      word returned by instruction memory
//   pc_address                           PC driven to instruction memory
//   if_id_instr, if_id_pc, if_id_valid   IF/ID pipeline register
//   halted, fault, fetch_count           status
// Modports: master = fetch_unit side, slave = surrounding pipeline/memory side.

interface fetch_unit_if;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] instruction_set;
    logic [31:0] pc_address;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic        if_id_valid;
    logic        halted;
    logic        fault;
    logic [31:0] fetch_count;

    modport master (
        input  stall,
        input  branch_taken,
        input  branch_target,
        input  instruction_set,
        output pc_address,
        output if_id_instr,
        output if_id_pc,
        output if_id_valid,
        output halted,
        output fault,
        output fetch_count
    );

    modport slave (
        output stall,
        output branch_taken,
        output branch_target,
        output instruction_set,
        input  pc_address,
        input  if_id_instr,
        input  if_id_pc,
        input  if_id_valid,
        input  halted,
        input  fault,
        input  fetch_count
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with IF/ID register, branch redirect and halt
//
// Purpose: owns the program counter, presents it to instruction memory,
// captures the returned word with its PC into IF/ID, and handles stalls,
// taken-branch redirects (with flush) and the end-of-program halt.
// Ports:
//   clk   single clock, all state updates on posedge
//   rst   synchronous active-high reset
//   bus   fetch_unit_if.master (control inputs, memory address/data, IF/ID, status)
// Parameters:
//   RESET_PC    PC loaded on reset (word aligned)
//   IMEM_WORDS  instruction memory depth in words; PC limit is IMEM_WORDS*4
//   NOP_INSTR   bubble word shown on if_id_instr while IF/ID is invalid

module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 32,
    parameter logic [31:0] NOP_INSTR  = 32'hE1A0_0000
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS * 4);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ifpc_q, ifpc_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;
    logic [31:0] count_q, count_d;
    logic        target_ok;
    logic        pc_in_range;

    // A redirect is only honoured if it lands on a word inside instruction memory.
    assign target_ok   = (bus.branch_target[1:0] == 2'b00) && (bus.branch_target < PC_LIMIT);
    assign pc_in_range = (pc_q < PC_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;
        valid_d = valid_q;
        fault_d = fault_q;
        count_d = count_q;

        case (state_q)
            RUN: begin
                if (bus.branch_taken) begin
                    // Redirect wins over stall: the instruction in IF/ID is on the
                    // wrong path either way, so it is dropped.
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                    if (target_ok) begin
                        pc_d = bus.branch_target;
                    end else begin
                        fault_d = 1'b1;
                        state_d = HALT;
                    end
                end else if (bus.stall) begin
                    // Everything holds; defaults already cover it.
                end else if (pc_in_range) begin
                    instr_d = bus.instruction_set;
                    ifpc_d  = pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_q + 32'd4;
                    count_d = count_q + 32'd1;
                end else begin
                    // Ran off the end of the program: PC is left pointing past it.
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                    state_d = HALT;
                end
            end

            HALT: begin
                valid_d = 1'b0;
                instr_d = NOP_INSTR;
                if (bus.branch_taken) begin
                    if (target_ok) begin
                        // Restart leaves fault untouched; only reset clears it.
                        pc_d    = bus.branch_target;
                        state_d = RUN;
                    end else begin
                        fault_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            ifpc_q  <= 32'h0000_0000;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            count_q <= 32'h0000_0000;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            count_q <= count_d;
        end
    end

    assign bus.pc_address  = pc_q;
    assign bus.if_id_instr = instr_q;
    assign bus.if_id_pc    = ifpc_q;
    assign bus.if_id_valid = valid_q;
    assign bus.halted      = (state_q == HALT);
    assign bus.fault       = fault_q;
    assign bus.fetch_count = count_q;

endmodule
